cp0_interrupt_unit: RTL and testbench

CPU-side consumer of the memory-mapped timer's interrupt line: a MIPS-style coprocessor-0 slice that holds Status, Cause and EPC, decides when a pending interrupt is taken, and supplies the handler return address. It sits in the single-cycle datapath beside the register file. Its inputs are `TimerInterrupt` and other device lines, plus the MTC0/MFC0/ERET decode. Its outputs are `TakenInterrupt`, which redirects the PC to the handler, and `EPC`, which ERET uses as its return target. The interrupt handler clears the interrupt at its source by storing to the device's acknowledge address.

---
 rtl/cp0_interrupt_unit_pkg.sv | 20 ++
 rtl/cp0_interrupt_unit_reg.sv | 29 ++
 rtl/cp0_interrupt_unit.sv | 141 ++++++++++++++
 tb/tb_cp0_interrupt_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_interrupt_unit_pkg.sv
// Shared definitions for the CP0 interrupt slice.
// Holds the CP0 register numbers used by MFC0/MTC0 and the bit positions of
// the Status fields, so the top module and any future CP0 logic agree on them.
package cp0_interrupt_unit_pkg;

    // CP0 register indices
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Status / Cause bit positions
    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int IM_LO  = 8;
    localparam int IM_HI  = 15;

    // Width of the IM / IP fields
    localparam int IRQ_FIELD_W = IM_HI - IM_LO + 1;

endpackage : cp0_interrupt_unit_pkg

// File: rtl/cp0_interrupt_unit_reg.sv
// cp0_reg: parameterized-width enabled register with asynchronous,
// active-high reset to a configurable value.
// Ports:
//   clock_i  - rising-edge clock
//   reset_i  - asynchronous active-high reset, loads reset_value
//   en_i     - load enable; when low the register holds
//   d_i      - next value
//   q_o      - registered value
module cp0_reg #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] reset_value = '0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // State register with async reset and load enable
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            q_o <= reset_value;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule : cp0_reg

// File: rtl/cp0_interrupt_unit.sv
// cp0_interrupt_unit: MIPS-style coprocessor-0 slice holding Status, Cause
// and EPC. Decides when a pending hardware interrupt is taken and supplies
// the ERET return address.
// Ports:
//   clock          - single rising-edge clock
//   reset          - asynchronous active-high reset (Status=0, EPC=0)
//   hw_irq         - level interrupt lines, MSB is the timer (IP[15])
//   regnum         - CP0 register index for MFC0/MTC0
//   wr_data        - MTC0 source value
//   MTC0           - write wr_data to regnum at the next edge
//   ERET           - exception return this cycle (clears EXL)
//   next_pc        - word address captured into EPC on a taken interrupt
//   rd_data        - combinational MFC0 read value for regnum
//   EPC            - exception PC (word address)
//   TakenInterrupt - combinational: interrupt accepted this cycle
module cp0_interrupt_unit
    import cp0_interrupt_unit_pkg::*;
#(
    parameter int NUM_HW_IRQ = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_HW_IRQ-1:0] hw_irq,
    input  logic [4:0]            regnum,
    input  logic [31:0]           wr_data,
    input  logic                  MTC0,
    input  logic                  ERET,
    input  logic [29:0]           next_pc,
    output logic [31:0]           rd_data,
    output logic [29:0]           EPC,
    output logic                  TakenInterrupt
);

    logic [IRQ_FIELD_W-1:0] im_q;
    logic                   exl_q;
    logic                   ie_q;
    logic [29:0]            epc_q;

    logic [IRQ_FIELD_W-1:0] ip_s;
    logic                   pending_s;
    logic                   taken_s;
    logic                   wr_status_s;
    logic                   wr_epc_s;
    logic                   exl_en_s;
    logic                   exl_d;
    logic                   epc_en_s;
    logic [29:0]            epc_d;

    // Cause.IP: hardware lines left-aligned so the timer lands on IP[15]
    always_comb begin
        ip_s = {IRQ_FIELD_W{1'b0}};
        ip_s[IRQ_FIELD_W-1 -: NUM_HW_IRQ] = hw_irq;
    end

    // Interrupt acceptance and MTC0 decode
    always_comb begin
        pending_s   = |(ip_s & im_q);
        taken_s     = pending_s & ie_q & ~exl_q;
        wr_status_s = MTC0 & (regnum == CP0_STATUS);
        wr_epc_s    = MTC0 & (regnum == CP0_EPC);
    end

    // EXL next state: a taken interrupt beats ERET, ERET beats an MTC0 write
    always_comb begin
        exl_en_s = taken_s | ERET | wr_status_s;
        if (taken_s) begin
            exl_d = 1'b1;
        end else if (ERET) begin
            exl_d = 1'b0;
        end else begin
            exl_d = wr_data[ST_EXL];
        end
    end

    // EPC next state: capture of next_pc beats a software write
    always_comb begin
        epc_en_s = taken_s | wr_epc_s;
        if (taken_s) begin
            epc_d = next_pc;
        end else begin
            epc_d = wr_data[31:2];
        end
    end

    cp0_reg #(.WIDTH(IRQ_FIELD_W), .reset_value({IRQ_FIELD_W{1'b0}})) u_im (
        .clock_i (clock),
        .reset_i (reset),
        .en_i    (wr_status_s),
        .d_i     (wr_data[IM_HI:IM_LO]),
        .q_o     (im_q)
    );

    cp0_reg #(.WIDTH(1), .reset_value(1'b0)) u_ie (
        .clock_i (clock),
        .reset_i (reset),
        .en_i    (wr_status_s),
        .d_i     (wr_data[ST_IE]),
        .q_o     (ie_q)
    );

    cp0_reg #(.WIDTH(1), .reset_value(1'b0)) u_exl (
        .clock_i (clock),
        .reset_i (reset),
        .en_i    (exl_en_s),
        .d_i     (exl_d),
        .q_o     (exl_q)
    );

    cp0_reg #(.WIDTH(30), .reset_value(30'h0)) u_epc (
        .clock_i (clock),
        .reset_i (reset),
        .en_i    (epc_en_s),
        .d_i     (epc_d),
        .q_o     (epc_q)
    );

    // MFC0 read mux; unimplemented registers and bits read zero
    always_comb begin
        rd_data = 32'h0;
        case (regnum)
            CP0_STATUS: begin
                rd_data[IM_HI:IM_LO] = im_q;
                rd_data[ST_EXL]      = exl_q;
                rd_data[ST_IE]       = ie_q;
            end
            CP0_CAUSE: begin
                rd_data[IM_HI:IM_LO] = ip_s;
            end
            CP0_EPC: begin
                rd_data = {epc_q, 2'b00};
            end
            default: begin
                rd_data = 32'h0;
            end
        endcase
    end

    assign EPC            = epc_q;
    assign TakenInterrupt = taken_s;

endmodule : cp0_interrupt_unit

// File: tb/tb_cp0_interrupt_unit.sv
// Self-checking bench for cp0_interrupt_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// CP0 Status/Cause/EPC rules.
module tb_cp0_interrupt_unit;

    localparam int N = 6;

    logic          clock;
    logic          reset;
    logic [N-1:0]  hw_irq;
    logic [4:0]    regnum;
    logic [31:0]   wr_data;
    logic          MTC0;
    logic          ERET;
    logic [29:0]   next_pc;
    logic [31:0]   rd_data;
    logic [29:0]   EPC;
    logic          TakenInterrupt;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int unsigned m_im;
    int unsigned m_ie;
    int unsigned m_exl;
    int unsigned m_epc;

    cp0_interrupt_unit #(.NUM_HW_IRQ(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .hw_irq         (hw_irq),
        .regnum         (regnum),
        .wr_data        (wr_data),
        .MTC0           (MTC0),
        .ERET           (ERET),
        .next_pc        (next_pc),
        .rd_data        (rd_data),
        .EPC            (EPC),
        .TakenInterrupt (TakenInterrupt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int unsigned model_ip();
        // lines occupy IP[15:16-N]; as an 8-bit field that is a shift by 8-N
        return int'(hw_irq) * (1 << (8 - N));
    endfunction

    function automatic int unsigned model_taken();
        int unsigned pend;
        pend = ((model_ip() & m_im) != 0) ? 1 : 0;
        return (pend == 1 && m_ie == 1 && m_exl == 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] rn);
        int unsigned v;
        case (rn)
            5'd12:   v = m_im * 256 + m_exl * 2 + m_ie;
            5'd13:   v = model_ip() * 256;
            5'd14:   v = m_epc * 4;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_im = 0; m_ie = 0; m_exl = 0; m_epc = 0;
    endtask

    // one clock edge of the architectural rules
    task automatic model_edge();
        int unsigned take;
        take = model_taken();
        if (MTC0 && regnum == 5'd12) begin
            m_im = (wr_data >> 8) & 32'hFF;
            m_ie = wr_data & 32'h1;
        end
        if (take == 1) begin
            m_exl = 1;
            m_epc = next_pc;
        end else begin
            if (ERET) m_exl = 0;
            else if (MTC0 && regnum == 5'd12) m_exl = (wr_data >> 1) & 32'h1;
            if (MTC0 && regnum == 5'd14) m_epc = wr_data >> 2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] irq, input logic [4:0] rn, input logic [31:0] wd,
                         input logic mt, input logic er, input logic [29:0] npc);
        hw_irq = irq; regnum = rn; wr_data = wd; MTC0 = mt; ERET = er; next_pc = npc;
    endtask

    // check outputs against the model, then advance one clock
    task automatic tick(input string tag);
        #1;
        chk({tag, "_taken"}, {31'h0, TakenInterrupt}, model_taken());
        chk({tag, "_rd"}, rd_data, model_rd(regnum));
        chk({tag, "_epc"}, {2'b00, EPC}, m_epc);
        @(posedge clock);
        if (!reset) model_edge();
        @(negedge clock);
    endtask

    localparam logic [N-1:0] TMR = 6'b100000;

    initial begin
        model_reset();
        reset = 1'b1;
        drive(6'h0, 5'd12, 32'h0, 1'b0, 1'b0, 30'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // reset state
        #1;
        chk("reset_status", rd_data, 32'h0);
        chk("reset_taken", {31'h0, TakenInterrupt}, 32'h0);
        chk("reset_epc", {2'b00, EPC}, 32'h0);
        tick("reset");

        // timer high but IE=0
        drive(TMR, 5'd12, 32'h0, 1'b0, 1'b0, 30'h0);
        #1 chk("ie0_no_take", {31'h0, TakenInterrupt}, 32'h0);
        tick("ie0");

        // enable timer: take asserts in the following cycle
        drive(TMR, 5'd12, 32'h8001, 1'b1, 1'b0, 30'h0);
        tick("mtc0_status");
        drive(TMR, 5'd12, 32'h0, 1'b0, 1'b0, 30'h0010_0004);
        #1 chk("take_first", {31'h0, TakenInterrupt}, 32'h1);
        tick("take1");
        #1;
        chk("epc_captured", {2'b00, EPC}, 32'h0010_0004);
        chk("status_exl", rd_data, 32'h0000_8003);
        chk("masked_exl", {31'h0, TakenInterrupt}, 32'h0);
        tick("held1");
        tick("held2");

        // ERET: line still held, taken again next cycle
        drive(TMR, 5'd12, 32'h0, 1'b0, 1'b1, 30'h0000_0100);
        tick("eret1");
        drive(TMR, 5'd12, 32'h0, 1'b0, 1'b0, 30'h0000_0200);
        #1 chk("retake", {31'h0, TakenInterrupt}, 32'h1);
        tick("retake");

        // acknowledge (drop line) and return
        drive(6'h0, 5'd12, 32'h0, 1'b0, 1'b1, 30'h0);
        tick("ack_eret");
        #1 chk("ack_no_take", {31'h0, TakenInterrupt}, 32'h0);

        // take coincides with MTC0 EPC: captured next_pc wins
        drive(TMR, 5'd14, 32'h0000_4000, 1'b1, 1'b0, 30'h0000_2222);
        #1 chk("take_vs_mtc0", {31'h0, TakenInterrupt}, 32'h1);
        tick("take_mtc0");
        #1 chk("epc_take_wins", {2'b00, EPC}, 32'h0000_2222);
        drive(TMR, 5'd13, 32'h0, 1'b0, 1'b0, 30'h0);
        #1 chk("cause_timer", rd_data, 32'h0000_8000);
        tick("cause");

        // leave handler, drop line, then software-set EXL
        drive(6'h0, 5'd12, 32'h0, 1'b0, 1'b1, 30'h0);
        tick("eret2");
        drive(6'h0, 5'd12, 32'h8003, 1'b1, 1'b0, 30'h0);
        tick("sw_exl");
        drive(TMR, 5'd12, 32'h0, 1'b0, 1'b0, 30'h0000_0300);
        #1;
        chk("sw_exl_status", rd_data, 32'h0000_8003);
        chk("sw_exl_masks", {31'h0, TakenInterrupt}, 32'h0);
        tick("sw_exl_hold");
        drive(TMR, 5'd12, 32'h8001, 1'b1, 1'b0, 30'h0000_0300);
        tick("sw_exl_clr");
        drive(TMR, 5'd12, 32'h0, 1'b0, 1'b0, 30'h0000_0400);
        #1 chk("take_resume", {31'h0, TakenInterrupt}, 32'h1);
        tick("resume");

        // async reset mid-handler, between edges
        reset = 1'b1;
        #2;
        model_reset();
        chk("areset_status", rd_data, 32'h0);
        chk("areset_epc", {2'b00, EPC}, 32'h0);
        chk("areset_taken", {31'h0, TakenInterrupt}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rn;
            case ($urandom_range(0, 4))
                0: rn = 5'd12;
                1: rn = 5'd13;
                2: rn = 5'd14;
                3: rn = 5'd12;
                default: rn = 5'($urandom);
            endcase
            drive(N'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  rn,
                  $urandom,
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  30'($urandom));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cp0_interrupt_unit
